// File: rtl/scara_cmd_pkg.sv
// Command encoding shared by the command feeder and the SCARA motion controller.
// Holds the opcode enum, field widths and the opcode validity check.
package scara_cmd_pkg;

  localparam int CMD_W     = 4;
  localparam int OPERAND_W = 14;
  localparam int ENTRY_W   = CMD_W + 2 * OPERAND_W;

  typedef enum logic [CMD_W-1:0] {
    G00 = 4'd0,
    G01 = 4'd1,
    G20 = 4'd2,
    G21 = 4'd3,
    G90 = 4'd4,
    G91 = 4'd5,
    M2  = 4'd6,
    M6  = 4'd7,
    M72 = 4'd8
  } opcode_e;

  localparam logic [CMD_W-1:0] OPCODE_LIMIT = 4'(M72);

  function automatic logic opcode_valid(input logic [CMD_W-1:0] op);
    return op <= OPCODE_LIMIT;
  endfunction

endpackage

// File: rtl/cmd_fifo_mem.sv
// Circular command storage: DEPTH x WIDTH array with one write and one read port.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module cmd_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Array contents need no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/command_feeder.sv
// Buffers loader commands and presents them show-ahead to the motion controller,
// halting after an M2 until start, with sticky overflow / bad-opcode flags.
module command_feeder
  import scara_cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [CMD_W-1:0]           wr_cmd,
  input  logic [OPERAND_W-1:0]       wr_x,
  input  logic [OPERAND_W-1:0]       wr_y,
  output logic                       full,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       block,
  input  logic                       controller_ready,
  output logic                       memory_ready,
  output logic [CMD_W-1:0]           cmd,
  output logic [OPERAND_W-1:0]       x_value,
  output logic [OPERAND_W-1:0]       y_value,
  output logic                       program_done,
  output logic                       overflow,
  output logic                       bad_opcode,
  output logic [$clog2(DEPTH)+1:0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic               cmd_ok;
  logic               stg_wr;
  logic               stg_rd;
  logic               stg_empty;
  logic [AW:0]        stg_count;
  logic [ENTRY_W-1:0] stg_rdata;
  logic               pres_valid;
  logic               pop;
  logic               load;

  assign cmd_ok       = opcode_valid(wr_cmd);
  assign stg_wr       = wr_en & cmd_ok & ~full & ~clear;
  assign memory_ready = pres_valid & ~program_done;
  assign pop          = memory_ready & controller_ready & ~block;
  assign load         = (~pres_valid | pop) & ~stg_empty;
  assign stg_rd       = load & ~clear;
  assign level        = (AW+2)'(stg_count) + (AW+2)'(pres_valid);

  cmd_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .wr_en   (stg_wr),
    .wr_data ({wr_cmd, wr_x, wr_y}),
    .rd_en   (stg_rd),
    .rd_data (stg_rdata),
    .full    (full),
    .empty   (stg_empty),
    .count   (stg_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_valid <= 1'b0;
      cmd        <= '0;
      x_value    <= '0;
      y_value    <= '0;
    end else if (clear) begin
      pres_valid <= 1'b0;
      cmd        <= '0;
      x_value    <= '0;
      y_value    <= '0;
    end else if (load) begin
      pres_valid                <= 1'b1;
      {cmd, x_value, y_value}   <= stg_rdata;
    end else if (pop) begin
      pres_valid <= 1'b0;
    end
  end

  // The entry behind an M2 still loads into the presentation register; it is
  // only withheld from the controller until start releases the halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      program_done <= 1'b0;
      overflow     <= 1'b0;
      bad_opcode   <= 1'b0;
    end else if (clear) begin
      program_done <= 1'b0;
      overflow     <= 1'b0;
      bad_opcode   <= 1'b0;
    end else begin
      if (pop && cmd == 4'(M2))
        program_done <= 1'b1;
      else if (start)
        program_done <= 1'b0;
      if (wr_en && !cmd_ok)
        bad_opcode <= 1'b1;
      if (wr_en && cmd_ok && full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_command_feeder.sv
// Scoreboard bench for command_feeder: accepted writes are queued as expected
// entries and a negedge monitor checks every entry the controller consumes.
module tb_command_feeder;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_cmd = '0;
  logic [13:0]   wr_x = '0;
  logic [13:0]   wr_y = '0;
  logic          full;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          block = 1'b0;
  logic          controller_ready = 1'b0;
  logic          memory_ready;
  logic [3:0]    cmd;
  logic [13:0]   x_value;
  logic [13:0]   y_value;
  logic          program_done;
  logic          overflow;
  logic          bad_opcode;
  logic [LW-1:0] level;

  int          n_compared = 0;
  int          n_mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  command_feeder #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_en            (wr_en),
    .wr_cmd           (wr_cmd),
    .wr_x             (wr_x),
    .wr_y             (wr_y),
    .full             (full),
    .clear            (clear),
    .start            (start),
    .block            (block),
    .controller_ready (controller_ready),
    .memory_ready     (memory_ready),
    .cmd              (cmd),
    .x_value          (x_value),
    .y_value          (y_value),
    .program_done     (program_done),
    .overflow         (overflow),
    .bad_opcode       (bad_opcode),
    .level            (level)
  );

  always #5 clk = ~clk;

  // Inputs change #1 after posedge, so at negedge they show what the next edge will do.
  always @(negedge clk) begin
    if (rst_n && memory_ready && controller_ready && !block) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL pop_unexpected: got %h with nothing expected", {cmd, x_value, y_value});
      end else begin
        exp_w = exp_q.pop_front();
        if ({cmd, x_value, y_value} !== exp_w) begin
          n_mismatched++;
          $display("[TB] FAIL pop_data: got cmd=%0d x=%0d y=%0d expected cmd=%0d x=%0d y=%0d",
                   cmd, x_value, y_value, exp_w[31:28], exp_w[27:14], exp_w[13:0]);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_write(input logic [3:0] c, input logic [13:0] x, input logic [13:0] y,
                             input bit accept);
    wr_en  = 1'b1;
    wr_cmd = c;
    wr_x   = x;
    wr_y   = y;
    if (accept)
      exp_q.push_back({c, x, y});
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check_output({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0] fill_ops [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd1};
    int n;
    int writes;

    $display("[TB] reset state");
    #12;
    check_output("rst_memory_ready", memory_ready, 0);
    check_output("rst_level", level, 0);
    check_output("rst_full", full, 0);
    check_output("rst_cmd_xy", {cmd, x_value, y_value}, 0);
    check_output("rst_flags", {program_done, overflow, bad_opcode}, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("[TB] first write latency");
    apply_write(4'd1, 14'd100, 14'd200, 1'b1);
    check_output("lat_not_yet_ready", memory_ready, 0);
    check_output("lat_level_storage", level, 1);
    tick();
    check_output("lat_ready", memory_ready, 1);
    check_output("lat_cmd", cmd, 1);
    check_output("lat_x", x_value, 100);
    check_output("lat_y", y_value, 200);
    check_output("lat_level", level, 1);

    // One entry already sits in the presentation register, so 8 more fill storage.
    $display("[TB] fill and overflow");
    for (int i = 0; i < 8; i++)
      apply_write(fill_ops[i], 14'(10 * (i + 1)), 14'(1000 + i), 1'b1);
    check_output("fill_full", full, 1);
    check_output("fill_level", level, 9);
    check_output("fill_no_overflow", overflow, 0);
    apply_write(4'd4, 14'd999, 14'd999, 1'b0);
    check_output("ovf_flag", overflow, 1);
    check_output("ovf_level", level, 9);
    check_output("ovf_cmd_kept", {cmd, x_value, y_value}, {4'd1, 14'd100, 14'd200});

    $display("[TB] block then drain");
    controller_ready = 1'b1;
    block = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("blk_ready", memory_ready, 1);
      check_output("blk_data", {cmd, x_value, y_value}, {4'd1, 14'd100, 14'd200});
      check_output("blk_level", level, 9);
    end
    block = 1'b0;
    repeat (8) tick();
    check_output("drain_level_8", level, 1);
    tick();
    check_output("drain_level_9", level, 0);
    check_output("drain_ready", memory_ready, 0);
    check_output("drain_q", exp_q.size(), 0);
    controller_ready = 1'b0;

    $display("[TB] M2 halt and start");
    apply_write(4'd4, 14'd1, 14'd2, 1'b1);
    apply_write(4'd6, 14'd3, 14'd4, 1'b1);
    apply_write(4'd0, 14'd5, 14'd6, 1'b1);
    controller_ready = 1'b1;
    n = 0;
    while (!program_done && n < 10) begin
      tick();
      n++;
    end
    check_output("m2_done", program_done, 1);
    check_output("m2_ready_low", memory_ready, 0);
    check_output("m2_level", level, 1);
    tick();
    check_output("m2_still_halted", memory_ready, 0);
    check_output("m2_retained", level, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("start_done_clr", program_done, 0);
    check_output("start_ready", memory_ready, 1);
    check_output("start_data", {cmd, x_value, y_value}, {4'd0, 14'd5, 14'd6});
    tick();
    check_output("start_level", level, 0);
    check_output("start_q", exp_q.size(), 0);
    controller_ready = 1'b0;

    $display("[TB] bad opcode and clear");
    apply_write(4'd1, 14'd7, 14'd8, 1'b1);
    apply_write(4'd12, 14'd9, 14'd9, 1'b0);
    check_output("bad_flag", bad_opcode, 1);
    check_output("bad_level", level, 1);
    check_output("bad_ovf_sticky", overflow, 1);
    clear = 1'b1;
    exp_q.delete();
    tick();
    clear = 1'b0;
    check_output("clr_bad", bad_opcode, 0);
    check_output("clr_ovf", overflow, 0);
    check_output("clr_level", level, 0);
    check_output("clr_ready", memory_ready, 0);

    $display("[TB] reset mid-operation");
    apply_write(4'd2, 14'd11, 14'd12, 1'b1);
    apply_write(4'd3, 14'd13, 14'd14, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    #3;
    check_output("mrst_ready", memory_ready, 0);
    check_output("mrst_level", level, 0);
    check_output("mrst_data", {cmd, x_value, y_value}, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check_output("mrst_no_stale", memory_ready, 0);
    controller_ready = 1'b1;
    apply_write(4'd5, 14'd21, 14'd22, 1'b1);
    wait_drain("mrst");
    controller_ready = 1'b0;

    $display("[TB] interleaved traffic across pointer wrap");
    writes = 0;
    n = 0;
    while (writes < 20 && n < 300) begin
      controller_ready = 1'($urandom_range(0, 1));
      if (!full) begin
        wr_en  = 1'b1;
        wr_cmd = fill_ops[writes % 8];
        wr_x   = 14'(37 * writes);
        wr_y   = 14'(16383 - writes);
        exp_q.push_back({wr_cmd, wr_x, wr_y});
        writes++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      n++;
    end
    wr_en = 1'b0;
    controller_ready = 1'b1;
    check_output("wrap_writes", writes, 20);
    wait_drain("wrap");
    tick();
    check_output("wrap_level", level, 0);
    check_output("wrap_flags", {overflow, bad_opcode}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/command_feeder.md
COMMAND_FEEDER -- requirements
Module: command_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning storage FIFO entries (power of two, 2..64).
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  loader write strobe.
- wr_cmd  in  4  opcode to enqueue.
- wr_x  in  14  X operand to enqueue.
- wr_y  in  14  Y operand to enqueue.
- full  out  1  storage holds DEPTH entries.
- clear  in  1  synchronous flush.
- start  in  1  one-cycle pulse that resumes after program end.
- block  in  1  controller hold; suppresses consumption.
- controller_ready  in  1  consumer can accept a command.
- memory_ready  out  1  cmd/x_value/y_value valid for consumption.
- cmd  out  4  presented opcode.
- x_value  out  14  presented X operand.
- y_value  out  14  presented Y operand.
- program_done  out  1  M2 consumed; presentation halted.
- overflow  out  1  sticky: write dropped because full.
- bad_opcode  out  1  sticky: write dropped because opcode invalid.
- level  out  $clog2(DEPTH)+2  entries held, storage plus presentation register.

Function
REQ-003 SHALL define the opcode encoding G00=0, G01=1, G20=2, G21=3, G90=4, G91=5, M2=6, M6=7, M72=8; values 9..15 are invalid.
REQ-004 SHALL consume (pop) the presented entry on a cycle with memory_ready & controller_ready & ~block; no other condition pops.
REQ-005 SHALL enqueue on wr_en when the opcode is valid and full=0; a write while full is dropped and sets overflow, even if a pop occurs in the same cycle.
REQ-006 SHALL drop a write with an invalid opcode and set bad_opcode; this check takes priority over the overflow check.
REQ-007 SHALL use a show-ahead presentation register: it loads the oldest storage entry when it is empty or being popped and storage is non-empty.
REQ-008 SHALL assert memory_ready the cycle after the edge at which the register loads, given a valid register and program_done=0; write at edge N into empty feeder -> memory_ready high after edge N+1.
REQ-009 SHALL sustain one pop per cycle while storage is non-empty and controller_ready=1, block=0.
REQ-010 SHALL hold cmd/x_value/y_value stable while memory_ready=1 and no pop occurs.
REQ-011 SHALL deassert memory_ready the cycle after a pop that leaves the feeder empty.
REQ-012 SHALL set program_done on the pop of an M2 entry and deassert memory_ready from the next cycle; remaining entries are retained.
REQ-013 SHALL clear program_done on start; presentation resumes the next cycle. start while program_done=0 has no effect.
REQ-014 SHALL handle a simultaneous write and pop as both taking effect, level unchanged, subject to REQ-005 and REQ-006.
REQ-015 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entry.
REQ-016 SHALL, on clear, empty storage and the presentation register, drop memory_ready, and clear program_done, overflow and bad_opcode next cycle; clear overrides a same-cycle write or pop.

Reset
REQ-017 SHALL, on rst_n low, asynchronously force: pointers=0, level=0, memory_ready=0, program_done=0, overflow=0, bad_opcode=0, full=0, cmd=0, x_value=0, y_value=0.
REQ-018 SHALL, after reset mid-operation, present no stale entry; the first memory_ready follows a fresh write.

Structure
REQ-019 SHALL take the opcode enum, command width 4, operand width 14 and the opcode validity limit from shared package scara_cmd_pkg, also used by the consumer.
REQ-020 SHALL place storage in sub-module cmd_fifo_mem (DEPTH x 32-bit, one write port, one read port, pointers and full/empty).

Verification
REQ-021 Bench SHALL cover the following scenarios:
- Reset, write {G01,x=100,y=200} at edge 5 -> memory_ready=1 after edge 6, cmd=1, x=100, y=200; level=1.
- 8 writes with controller_ready=0 -> full=1, level=9 (8 storage + presentation register); 9th storage-filling write sets overflow=1 and data is unchanged.
- controller_ready=1, block=1 for 3 cycles -> no pop, outputs stable; block=0 -> pops at 1/cycle in write order.
- Queue {G90, M2, G00 x=5}, controller_ready=1 -> G90 and M2 popped, program_done=1, memory_ready=0; start pulse -> G00 x=5 presented next cycle.
- Write cmd=12 -> bad_opcode=1, level unchanged; clear -> bad_opcode=0, level=0.
- 20 writes and pops interleaved at random -> popped sequence equals written sequence across pointer wrap.
